// File: rtl/debounce_filter_pkg.sv
// Shared types and constants for the debounce filter: FSM state encoding
// and synchronizer depth.
package debounce_filter_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b10,
    CHK_LO  = 2'b11
  } state_t;

  localparam int SYNC_DEPTH = 2;

  function automatic logic is_chk(input state_t st);
    return (st == CHK_HI) || (st == CHK_LO);
  endfunction

  function automatic logic is_high(input state_t st);
    return (st == IDLE_HI) || (st == CHK_LO);
  endfunction

endpackage

// File: rtl/debounce_filter_sync_2ff.sv
// Flop-chain synchronizer (SYNC_DEPTH stages) for an asynchronous 1-bit input,
// cleared to 0 by the synchronous active-low clear.
module sync_2ff
  import debounce_filter_pkg::*;
(
  input  logic clk,
  input  logic clear_n,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/debounce_filter.sv
// Counter-based debounce filter with registered q/qbar and rise/fall pulses.
// Define DEBOUNCE_FILTER_SYNC_EN to place a two-flop synchronizer ahead of the FSM.
module debounce_filter
  import debounce_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic clear_n,
  input  logic d,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             q_nxt, rise_nxt, fall_nxt, busy_nxt;

`ifdef DEBOUNCE_FILTER_SYNC_EN
  sync_2ff u_sync (
    .clk     (clk),
    .clear_n (clear_n),
    .d       (d),
    .q       (s)
  );
`else
  assign s = d;
`endif

  // State register; outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= IDLE_LO;
      cnt   <= '0;
      q     <= 1'b0;
      qbar  <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      qbar  <= ~q_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
    end
  end

  // Next-state logic: an opposite sample during a check aborts with no partial credit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE_LO: begin
        if (s) begin
          state_nxt = CHK_HI;
          cnt_nxt   = CNT_W'(1);
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_nxt = CHK_LO;
          cnt_nxt   = CNT_W'(1);
        end
      end
      CHK_LO: begin
        if (s) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: pulses fire only on a committed transition out of a check state.
  always_comb begin
    q_nxt    = is_high(state_nxt);
    busy_nxt = is_chk(state_nxt);
    rise_nxt = (state == CHK_HI) && (state_nxt == IDLE_HI);
    fall_nxt = (state == CHK_LO) && (state_nxt == IDLE_LO);
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Scoreboard bench for debounce_filter: a history-window reference model predicts
// {q,qbar,rise,fall,busy} per edge; a separate monitor pops and compares.
module tb_debounce_filter;

  localparam int SC = 4;

  logic clk = 1'b0;
  logic clear_n;
  logic d;
  logic q, qbar, rise, fall, busy;

  debounce_filter #(.STABLE_CYCLES(SC), .CNT_W(16)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .d       (d),
    .q       (q),
    .qbar    (qbar),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  logic [4:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Reference model state: samples seen since reset, pending synchronizer contents.
  logic m_q = 1'b0;
  logic samples[$];
  logic pipe[2] = '{1'b0, 1'b0};

  task automatic model_edge(input logic dv, input logic cn);
    logic s, commit, r, f, b;
    if (!cn) begin
      m_q = 1'b0;
      samples.delete();
      pipe[0] = 1'b0;
      pipe[1] = 1'b0;
      exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      return;
    end
`ifdef DEBOUNCE_FILTER_SYNC_EN
    s = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = dv;
`else
    s = dv;
`endif
    samples.push_back(s);
    if (samples.size() > SC) void'(samples.pop_front());
    // A change commits when the last SC samples since reset all oppose q.
    commit = (samples.size() == SC);
    foreach (samples[i]) if (samples[i] == m_q) commit = 1'b0;
    r = commit && !m_q;
    f = commit && m_q;
    if (commit) m_q = ~m_q;
    b = (s != m_q);
    exp_q.push_back({m_q, ~m_q, r, f, b});
  endtask

  task automatic cyc(input logic dv, input logic cn);
    d = dv;
    clear_n = cn;
    model_edge(dv, cn);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input logic dv, input int n);
    for (int i = 0; i < n; i++) cyc(dv, 1'b1);
  endtask

  // Monitor: compares the DUT outputs against the oldest pending expectation.
  initial begin
    logic [4:0] exp_v, act_v;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {q, qbar, rise, fall, busy};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs t=%0t {q,qbar,rise,fall,busy} got=%b want=%b",
                   $time, act_v, exp_v);
        end
      end
    end
  end

  initial begin
    int len;
    logic lvl;
    // Reset held with d=1, then release and let d=1 qualify.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    run(1'b1, 8);
    // Clean fall.
    run(1'b0, 8);
    // Glitch one sample short of qualifying, then a full qualification.
    run(1'b1, SC - 1);
    run(1'b0, 6);
    run(1'b1, 8);
    run(1'b0, 8);
    // Reset in the middle of a rising qualification, then restart.
    run(1'b1, 3);
    cyc(1'b1, 1'b0);
    run(1'b1, 8);
    run(1'b0, 8);
    // Randomized runs of varying length around the threshold, with rare resets.
    lvl = 1'b0;
    for (int k = 0; k < 150; k++) begin
      lvl = ~lvl;
      len = $urandom_range(1, SC + 3);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 59) == 0) cyc(lvl, 1'b0);
        else cyc(lvl, 1'b1);
      end
    end
    run(1'b0, 4);
    done = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
